// File: rtl/ctrl_pipeline_if.sv
// ID-stage control inputs and EX/MEM/WB control outputs of the pipeline control block.
// The decoder drives the inputs during the ID cycle; the inputs are sampled on the rising clock edge.
interface ctrl_pipeline_if;
  logic       RegWrite_i;
  logic       MemtoReg_i;
  logic       MemRead_i;
  logic       MemWrite_i;
  logic       ALUSrc_i;
  logic       Branch_i;
  logic [2:0] ALUOp_i;
  logic [4:0] rs1_i;
  logic [4:0] rs2_i;
  logic [4:0] rd_i;
  logic       flush_i;

  logic [2:0] ex_ALUOp_o;
  logic       ex_ALUSrc_o;
  logic       ex_Branch_o;
  logic       mem_MemRead_o;
  logic       mem_MemWrite_o;
  logic       wb_RegWrite_o;
  logic       wb_MemtoReg_o;
  logic [4:0] wb_rd_o;
  logic       stall_o;
  logic [1:0] fwd_a_o;
  logic [1:0] fwd_b_o;

  modport slave (
    input  RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i, Branch_i,
    input  ALUOp_i, rs1_i, rs2_i, rd_i, flush_i,
    output ex_ALUOp_o, ex_ALUSrc_o, ex_Branch_o, mem_MemRead_o, mem_MemWrite_o,
    output wb_RegWrite_o, wb_MemtoReg_o, wb_rd_o, stall_o, fwd_a_o, fwd_b_o
  );

  modport master (
    output RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i, Branch_i,
    output ALUOp_i, rs1_i, rs2_i, rd_i, flush_i,
    input  ex_ALUOp_o, ex_ALUSrc_o, ex_Branch_o, mem_MemRead_o, mem_MemWrite_o,
    input  wb_RegWrite_o, wb_MemtoReg_o, wb_rd_o, stall_o, fwd_a_o, fwd_b_o
  );
endinterface

// File: rtl/ctrl_pipeline.sv
// EX/MEM/WB control pipeline with load-use stall detection, flush bubbles and forwarding select.
// MEM and WB always advance; only the EX load is replaced by a bubble on a hazard or flush.
module ctrl_pipeline (
  input logic           clk_i,
  input logic           rst_i,
  ctrl_pipeline_if.slave bus
);
  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic       branch;
    logic [2:0] alu_op;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } ex_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic [4:0] rd;
  } mem_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic [4:0] rd;
  } wb_t;

  ex_t  ex_d,  ex_q;
  mem_t mem_d, mem_q;
  wb_t  wb_d,  wb_q;
  logic hazard;

  // MEM result is newer than WB result, so it wins when both match.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic mem_rw, input logic [4:0] mem_rd,
                                         input logic wb_rw,  input logic [4:0] wb_rd);
    if (mem_rw && (mem_rd != 5'd0) && (mem_rd == rs))
      return 2'b10;
    else if (wb_rw && (wb_rd != 5'd0) && (wb_rd == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  always_comb begin
    hazard = ex_q.mem_read && (ex_q.rd != 5'd0) &&
             ((ex_q.rd == bus.rs1_i) || (ex_q.rd == bus.rs2_i));
  end

  always_comb begin
    ex_d = '0;
    if (!(hazard || bus.flush_i)) begin
      ex_d.reg_write  = bus.RegWrite_i;
      ex_d.mem_to_reg = bus.MemtoReg_i;
      ex_d.mem_read   = bus.MemRead_i;
      ex_d.mem_write  = bus.MemWrite_i;
      ex_d.alu_src    = bus.ALUSrc_i;
      ex_d.branch     = bus.Branch_i;
      ex_d.alu_op     = bus.ALUOp_i;
      ex_d.rs1        = bus.rs1_i;
      ex_d.rs2        = bus.rs2_i;
      ex_d.rd         = bus.rd_i;
    end
    mem_d.reg_write  = ex_q.reg_write;
    mem_d.mem_to_reg = ex_q.mem_to_reg;
    mem_d.mem_read   = ex_q.mem_read;
    mem_d.mem_write  = ex_q.mem_write;
    mem_d.rd         = ex_q.rd;
    wb_d.reg_write   = mem_q.reg_write;
    wb_d.mem_to_reg  = mem_q.mem_to_reg;
    wb_d.rd          = mem_q.rd;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  assign bus.ex_ALUOp_o     = ex_q.alu_op;
  assign bus.ex_ALUSrc_o    = ex_q.alu_src;
  assign bus.ex_Branch_o    = ex_q.branch;
  assign bus.mem_MemRead_o  = mem_q.mem_read;
  assign bus.mem_MemWrite_o = mem_q.mem_write;
  assign bus.wb_RegWrite_o  = wb_q.reg_write;
  assign bus.wb_MemtoReg_o  = wb_q.mem_to_reg;
  assign bus.wb_rd_o        = wb_q.rd;
  // A flush already kills the ID instruction, so holding the front end would be wrong.
  assign bus.stall_o        = hazard && !bus.flush_i;
  assign bus.fwd_a_o        = fwd_sel(ex_q.rs1, mem_q.reg_write, mem_q.rd, wb_q.reg_write, wb_q.rd);
  assign bus.fwd_b_o        = fwd_sel(ex_q.rs2, mem_q.reg_write, mem_q.rd, wb_q.reg_write, wb_q.rd);
endmodule

// File: tb/tb_ctrl_pipeline.sv
// Directed and randomized checks of ctrl_pipeline against an instruction-level pipeline model.
module tb_ctrl_pipeline;
  typedef struct packed {
    logic       rw, mtr, mr, mw, as, br;
    logic [2:0] op;
    logic [4:0] rs1, rs2, rd;
  } instr_t;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  ctrl_pipeline_if bus();

  ctrl_pipeline dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // model: the instruction currently held in each stage
  instr_t ex_m, mem_m, wb_m;
  instr_t cur_id;
  logic   cur_flush;
  logic [6:0] exp_q[$];

  function automatic instr_t mk(input logic rw, mtr, mr, mw, as, br,
                                input logic [2:0] op, input logic [4:0] rs1, rs2, rd);
    instr_t x;
    x = '{rw: rw, mtr: mtr, mr: mr, mw: mw, as: as, br: br, op: op, rs1: rs1, rs2: rs2, rd: rd};
    return x;
  endfunction

  function automatic logic m_hazard(input instr_t ex, input instr_t id);
    return ex.mr && (ex.rd != 0) && (ex.rd == id.rs1 || ex.rd == id.rs2);
  endfunction

  function automatic logic [1:0] m_fwd(input logic [4:0] rs, input instr_t mem, input instr_t wb);
    if (mem.rw && mem.rd != 0 && mem.rd == rs) return 2'b10;
    if (wb.rw && wb.rd != 0 && wb.rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".ex_aluop"},  8'(bus.ex_ALUOp_o),     8'(ex_m.op));
    chk({tag, ".ex_alusrc"}, 8'(bus.ex_ALUSrc_o),    8'(ex_m.as));
    chk({tag, ".ex_branch"}, 8'(bus.ex_Branch_o),    8'(ex_m.br));
    chk({tag, ".mem_rd"},    8'(bus.mem_MemRead_o),  8'(mem_m.mr));
    chk({tag, ".mem_wr"},    8'(bus.mem_MemWrite_o), 8'(mem_m.mw));
    chk({tag, ".wb_rw"},     8'(bus.wb_RegWrite_o),  8'(wb_m.rw));
    chk({tag, ".wb_mtr"},    8'(bus.wb_MemtoReg_o),  8'(wb_m.mtr));
    chk({tag, ".wb_rd"},     8'(bus.wb_rd_o),        8'(wb_m.rd));
    chk({tag, ".stall"},     8'(bus.stall_o),        8'(m_hazard(ex_m, cur_id) && !cur_flush));
    chk({tag, ".fwd_a"},     8'(bus.fwd_a_o),        8'(m_fwd(ex_m.rs1, mem_m, wb_m)));
    chk({tag, ".fwd_b"},     8'(bus.fwd_b_o),        8'(m_fwd(ex_m.rs2, mem_m, wb_m)));
  endtask

  // driver tasks
  task automatic drive(input instr_t x, input logic fl);
    cur_id         = x;
    cur_flush      = fl;
    bus.RegWrite_i = x.rw;
    bus.MemtoReg_i = x.mtr;
    bus.MemRead_i  = x.mr;
    bus.MemWrite_i = x.mw;
    bus.ALUSrc_i   = x.as;
    bus.Branch_i   = x.br;
    bus.ALUOp_i    = x.op;
    bus.rs1_i      = x.rs1;
    bus.rs2_i      = x.rs2;
    bus.rd_i       = x.rd;
    bus.flush_i    = fl;
    #1;
  endtask

  task automatic tick(input string tag);
    instr_t enter;
    enter = (cur_flush || m_hazard(ex_m, cur_id)) ? '0 : cur_id;
    @(posedge clk);
    wb_m  = mem_m;
    mem_m = ex_m;
    ex_m  = enter;
    #1;
    check_all(tag);
  endtask

  task automatic model_reset();
    ex_m  = '0;
    mem_m = '0;
    wb_m  = '0;
  endtask

  instr_t nop, lw5, sw, a;

  initial begin
    tests = 0;
    fails = 0;
    nop = '0;
    lw5 = mk(1, 1, 1, 0, 1, 0, 3'b000, 5'd1, 5'd0, 5'd5);
    sw  = mk(0, 0, 0, 1, 1, 0, 3'b000, 5'd2, 5'd9, 5'd0);
    model_reset();

    // reset state: async clear before any clock edge
    rst_n = 1'b0;
    drive(nop, 1'b0);
    check_all("reset0");
    chk("reset0.stall_lit", 8'(bus.stall_o), 8'd0);
    @(posedge clk); #1;
    check_all("reset1");
    @(negedge clk);
    rst_n = 1'b1;

    // load-use: lw x5 then add rs1=5
    drive(lw5, 1'b0);
    tick("lw");
    drive(mk(1, 0, 0, 0, 0, 0, 3'b010, 5'd5, 5'd0, 5'd6), 1'b0);
    chk("lu.stall_lit", 8'(bus.stall_o), 8'd1);
    check_all("lu.id");
    tick("lu.bubble");
    chk("lu.bubble_op", 8'(bus.ex_ALUOp_o), 8'd0);
    chk("lu.bubble_src", 8'(bus.ex_ALUSrc_o), 8'd0);
    tick("lu.add");
    chk("lu.fwd_a_lit", 8'(bus.fwd_a_o), 8'b01);

    // EX->EX forwarding on both operands
    drive(mk(1, 0, 0, 0, 0, 0, 3'b010, 5'd1, 5'd2, 5'd3), 1'b0);
    tick("f10.add");
    drive(mk(1, 0, 0, 0, 0, 0, 3'b011, 5'd3, 5'd3, 5'd4), 1'b0);
    tick("f10.sub");
    chk("f10.fwd_a_lit", 8'(bus.fwd_a_o), 8'b10);
    chk("f10.fwd_b_lit", 8'(bus.fwd_b_o), 8'b10);

    // WB forwarding through a nop, then x0 destination never forwards
    drive(mk(1, 0, 0, 0, 0, 0, 3'b010, 5'd1, 5'd2, 5'd3), 1'b0);
    tick("f01.add");
    drive(nop, 1'b0);
    tick("f01.nop");
    drive(mk(1, 0, 0, 0, 0, 0, 3'b011, 5'd7, 5'd3, 5'd4), 1'b0);
    tick("f01.sub");
    chk("f01.fwd_b_lit", 8'(bus.fwd_b_o), 8'b01);
    drive(mk(1, 0, 0, 0, 0, 0, 3'b010, 5'd1, 5'd2, 5'd0), 1'b0);
    tick("fx0.add");
    drive(nop, 1'b0);
    tick("fx0.nop");
    drive(mk(1, 0, 0, 0, 0, 0, 3'b011, 5'd7, 5'd0, 5'd4), 1'b0);
    tick("fx0.sub");
    chk("fx0.fwd_b_lit", 8'(bus.fwd_b_o), 8'b00);

    // hazard plus flush in the same cycle
    drive(lw5, 1'b0);
    tick("fl.lw");
    drive(mk(1, 0, 0, 0, 0, 0, 3'b010, 5'd5, 5'd0, 5'd6), 1'b1);
    chk("fl.stall_lit", 8'(bus.stall_o), 8'd0);
    tick("fl.bubble");
    chk("fl.ex_op_lit", 8'(bus.ex_ALUOp_o), 8'd0);
    drive(nop, 1'b0);
    tick("fl.next");
    chk("fl.mem_rd_lit", 8'(bus.mem_MemRead_o), 8'd0);

    // reset mid-flight discards a store sitting in MEM
    drive(sw, 1'b0);
    tick("rs.sw");
    drive(nop, 1'b0);
    tick("rs.mem");
    chk("rs.mem_wr_before", 8'(bus.mem_MemWrite_o), 8'd1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rs.mem_wr_async", 8'(bus.mem_MemWrite_o), 8'd0);
    chk("rs.wb_rw_async", 8'(bus.wb_RegWrite_o), 8'd0);
    check_all("rs.async");
    @(posedge clk); #1;
    check_all("rs.held");
    @(negedge clk);
    rst_n = 1'b1;
    a = mk(0, 0, 0, 0, 1, 1, 3'b101, 5'd8, 5'd9, 5'd10);
    drive(a, 1'b0);
    tick("rs.release");
    chk("rs.release_op", 8'(bus.ex_ALUOp_o), 8'b101);

    // 20 random hazard-free vectors; wb_* tracks the ID inputs three edges later
    drive(nop, 1'b0);
    tick("rnd.pre");
    for (int i = 0; i < 20; i++) begin
      a = mk(1'($urandom), 1'($urandom), 1'b0, 1'($urandom), 1'($urandom), 1'($urandom),
             3'($urandom), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
             5'($urandom_range(0, 31)));
      drive(a, 1'b0);
      exp_q.push_back({a.rw, a.mtr, a.rd});
      tick("rnd");
      if (exp_q.size() == 3) begin
        logic [6:0] e;
        e = exp_q.pop_front();
        chk("rnd.wb_delay", 8'({bus.wb_RegWrite_o, bus.wb_MemtoReg_o, bus.wb_rd_o}), 8'(e));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ctrl_pipeline.md
CTRL_PIPELINE -- requirements
Module: ctrl_pipeline

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset SHALL be asynchronous and active-low.
REQ-002 clk_i  input  1  rising-edge clock for all state.
REQ-003 rst_i  input  1  asynchronous active-low reset.
REQ-004 RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i, Branch_i  input  1 each  ID-stage control bits from the opcode decoder.
REQ-005 ALUOp_i  input  3  ID-stage ALU operation class.
REQ-006 rs1_i, rs2_i, rd_i  input  5 each  ID-stage register indices.
REQ-007 flush_i  input  1  kill the ID-stage instruction this cycle.
REQ-008 ex_ALUOp_o  output  3; ex_ALUSrc_o, ex_Branch_o  output  1 each  EX-stage controls.
REQ-009 mem_MemRead_o, mem_MemWrite_o  output  1 each  MEM-stage controls.
REQ-010 wb_RegWrite_o, wb_MemtoReg_o  output  1 each; wb_rd_o  output  5  WB-stage controls and destination.
REQ-011 stall_o  output  1  hold PC and IF/ID register this cycle.
REQ-012 fwd_a_o, fwd_b_o  output  2 each  EX operand source: 00 register file, 10 MEM result, 01 WB result.

Function
REQ-013 Three register stages SHALL exist: EX (all control bits, rs1, rs2, rd), MEM (RegWrite, MemtoReg, MemRead, MemWrite, rd), WB (RegWrite, MemtoReg, rd).
REQ-014 Each rising edge SHALL advance EX->MEM->WB unconditionally; MEM and WB never stall.
REQ-015 Load-use hazard SHALL be: EX.MemRead=1 and EX.rd!=0 and (EX.rd==rs1_i or EX.rd==rs2_i); evaluated combinationally on current state and inputs.
REQ-016 stall_o SHALL equal hazard AND NOT flush_i.
REQ-017 EX load: if flush_i=1 or hazard=1, the EX stage SHALL load a bubble (all control bits 0, rs1=rs2=rd=0); otherwise it SHALL load the ID inputs.
REQ-018 flush_i SHALL take priority over a hazard in the same cycle: bubble inserted, stall_o=0.
REQ-019 A bubble SHALL produce no register write and no memory access as it travels to WB.
REQ-020 Latency: controls presented in ID at edge N SHALL appear on ex_* after edge N, mem_* after N+1, wb_* after N+2.
REQ-021 fwd_a_o SHALL be 10 if MEM.RegWrite and MEM.rd!=0 and MEM.rd==EX.rs1; else 01 if WB.RegWrite and WB.rd!=0 and WB.rd==EX.rs1; else 00.
REQ-022 fwd_b_o SHALL follow REQ-021 using EX.rs2; MEM match SHALL take precedence over WB match.
REQ-023 Register index x0 SHALL never cause a hazard or forward.
REQ-024 All outputs except stall_o and fwd_*_o SHALL be driven directly from stage registers (no combinational path from inputs).

Reset
REQ-025 On rst_i=0 all stage registers SHALL clear to 0 immediately, regardless of clock.
REQ-026 During and after reset, until new input is captured, every output SHALL be 0 (stall_o=0, fwd_a_o=fwd_b_o=00).
REQ-027 Reset asserted mid-operation SHALL discard all in-flight controls; no partial stage SHALL survive.
REQ-028 Release of rst_i SHALL take effect at the next rising edge with no extra wait cycles.

Verification
REQ-029 lw x5 (RegWrite=1, MemtoReg=1, MemRead=1, ALUSrc=1, ALUOp=000, rd=5) then add rs1=5 -> stall_o=1 for one cycle, EX bubble (ex_ALUOp_o=000, ex_ALUSrc_o=0), add enters EX next cycle with fwd_a_o=01.
REQ-030 add rd=3 followed by sub rs1=3, rs2=3 -> in sub's EX cycle fwd_a_o=10, fwd_b_o=10.
REQ-031 add rd=3, nop, sub rs2=3 -> fwd_b_o=01; with rd=0 instead -> fwd_b_o=00.
REQ-032 Load-use hazard with flush_i=1 same cycle -> stall_o=0, bubble in EX, mem_MemRead_o=0 one cycle later.
REQ-033 sw (MemWrite=1) at edge N, rst_i pulled low between edges N+1 and N+2 -> mem_MemWrite_o drops to 0 asynchronously, wb_RegWrite_o=0.
REQ-034 Back-to-back 20 random decoder vectors without hazards -> wb_* equal ID inputs delayed exactly 3 edges, matching a reference model.
